// File: rtl/tlb_refill_unit.sv
// tlb_refill_unit: ITLB/DTLB miss refill sequencer that reads the PTE over a valid/ready port and returns a fill or a page fault.
module tlb_refill_unit #(
  parameter int CORE_ID = 0,
  parameter int ADDR_WIDTH = 32,
  parameter int PAGE_SHIFT = 12,
  parameter int INDEX_BITS = 8,
  parameter logic [ADDR_WIDTH-1:0] DTLB_BASE = 'h4000,
  parameter logic [ADDR_WIDTH-1:0] ITLB_BASE = 'h4400,
  parameter logic [ADDR_WIDTH-1:0] CORE_STRIDE = 'h800
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dtlb_miss_valid,
  input  logic [ADDR_WIDTH-1:0]        dtlb_miss_vaddr,
  input  logic                         itlb_miss_valid,
  input  logic [ADDR_WIDTH-1:0]        itlb_miss_vaddr,
  output logic                         dtlb_miss_ready,
  output logic                         itlb_miss_ready,
  input  logic                         flush,
  output logic                         mem_req_valid,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_rsp_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_rsp_data,
  output logic                         fill_valid,
  output logic                         fill_is_dtlb,
  output logic [ADDR_WIDTH-PAGE_SHIFT-1:0] fill_vpn,
  output logic [ADDR_WIDTH-PAGE_SHIFT-1:0] fill_ppn,
  output logic                         page_fault,
  output logic                         busy
);
  localparam int VW = ADDR_WIDTH - PAGE_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] REGION = ADDR_WIDTH'(CORE_ID) * CORE_STRIDE;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_e;
  state_e state_q, state_d;
  logic is_dtlb_q, is_dtlb_d, abort_q, abort_d, pte_ok_q, pte_ok_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [VW-1:0] vpn_q, vpn_d, ppn_q, ppn_d, miss_vpn;
  logic take;
  logic unused_ok;
  assign unused_ok = ^{mem_rsp_data[PAGE_SHIFT-1:1], dtlb_miss_vaddr[PAGE_SHIFT-1:0], itlb_miss_vaddr[PAGE_SHIFT-1:0]};
  assign take = (state_q == IDLE) && !flush && (dtlb_miss_valid || itlb_miss_valid);
  assign miss_vpn = dtlb_miss_valid ? dtlb_miss_vaddr[ADDR_WIDTH-1:PAGE_SHIFT] : itlb_miss_vaddr[ADDR_WIDTH-1:PAGE_SHIFT];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      is_dtlb_q <= 1'b0;
      abort_q   <= 1'b0;
      pte_ok_q  <= 1'b0;
      addr_q    <= '0;
      vpn_q     <= '0;
      ppn_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_dtlb_q <= is_dtlb_d;
      abort_q   <= abort_d;
      pte_ok_q  <= pte_ok_d;
      addr_q    <= addr_d;
      vpn_q     <= vpn_d;
      ppn_q     <= ppn_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    is_dtlb_d = is_dtlb_q;
    abort_d   = abort_q;
    pte_ok_d  = pte_ok_q;
    addr_d    = addr_q;
    vpn_d     = vpn_q;
    ppn_d     = ppn_q;
    case (state_q)
      IDLE: if (take) begin
        state_d   = REQ;
        is_dtlb_d = dtlb_miss_valid;
        vpn_d     = miss_vpn;
        abort_d   = 1'b0;
        addr_d    = (dtlb_miss_valid ? DTLB_BASE : ITLB_BASE) + REGION + (ADDR_WIDTH'(miss_vpn[INDEX_BITS-1:0]) << 2);
      end
      REQ: begin
        state_d = mem_req_ready ? WAIT : (flush ? IDLE : REQ);
        abort_d = mem_req_ready && flush;
      end
      WAIT: begin
        abort_d = abort_q || flush;
        if (mem_rsp_valid) begin
          state_d  = FILL;
          ppn_d    = mem_rsp_data[ADDR_WIDTH-1:PAGE_SHIFT];
          pte_ok_d = mem_rsp_data[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dtlb_miss_ready = (state_q == IDLE) && !flush && dtlb_miss_valid;
    itlb_miss_ready = (state_q == IDLE) && !flush && !dtlb_miss_valid && itlb_miss_valid;
    mem_req_valid   = state_q == REQ;
    mem_req_addr    = addr_q;
    fill_valid      = (state_q == FILL) && !abort_q && pte_ok_q;
    page_fault      = (state_q == FILL) && !abort_q && !pte_ok_q;
    fill_is_dtlb    = is_dtlb_q;
    fill_vpn        = vpn_q;
    fill_ppn        = ppn_q;
    busy            = state_q != IDLE;
  end
endmodule

// File: doc/tlb_refill_unit.md
Name: tlb_refill_unit

Overview:
Hardware TLB-miss refill sequencer for one Elpis core. It accepts ITLB and DTLB miss requests and forms the page-table entry address from a per-core, per-TLB base plus an indexed VPN offset. It fetches the PTE over a valid/ready memory port and returns either a fill or a page fault to the requesting TLB. It is the sequential, multi-core-aware successor of the fixed-offset TLB handler address adder.

Parameters:
CORE_ID, 0, core index; selects this core's table region
ADDR_WIDTH, 32, address and PTE width in bits
PAGE_SHIFT, 12, log2 page size; VPN = vaddr[ADDR_WIDTH-1:PAGE_SHIFT]
INDEX_BITS, 8, VPN low bits used as table index (2^INDEX_BITS entries per table)
DTLB_BASE, 32'h0000_4000, DTLB table base for core 0
ITLB_BASE, 32'h0000_4400, ITLB table base for core 0
CORE_STRIDE, 32'h0000_0800, byte offset between consecutive cores' regions

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dtlb_miss_valid  in  1  DTLB miss pending
dtlb_miss_vaddr  in  ADDR_WIDTH  faulting data virtual address
itlb_miss_valid  in  1  ITLB miss pending
itlb_miss_vaddr  in  ADDR_WIDTH  faulting instruction virtual address
dtlb_miss_ready  out  1  DTLB miss accepted this cycle
itlb_miss_ready  out  1  ITLB miss accepted this cycle
flush  in  1  pipeline flush; abort the in-flight refill
mem_req_valid  out  1  PTE read request valid
mem_req_addr  out  ADDR_WIDTH  PTE address
mem_req_ready  in  1  memory accepts the request
mem_rsp_valid  in  1  PTE data valid
mem_rsp_data  in  ADDR_WIDTH  PTE: bit0 = valid, [ADDR_WIDTH-1:PAGE_SHIFT] = PPN
fill_valid  out  1  one-cycle TLB fill strobe
fill_is_dtlb  out  1  1 = fill/fault targets DTLB, 0 = ITLB
fill_vpn  out  ADDR_WIDTH-PAGE_SHIFT  VPN being filled
fill_ppn  out  ADDR_WIDTH-PAGE_SHIFT  PPN from the PTE
page_fault  out  1  one-cycle strobe; the PTE was invalid
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; every output 0, including the registered address, VPN, PPN and abort flag. Reset overrides all inputs in any state, mid-refill included. A response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, FILL.
- IDLE: the DTLB has priority. If dtlb_miss_valid: dtlb_miss_ready=1, capture the DTLB miss. Else if itlb_miss_valid: itlb_miss_ready=1, capture the ITLB miss. Readies are combinational and are asserted only in IDLE. On capture, move to REQ. flush in IDLE blocks acceptance for that cycle.
- Address, registered on capture: base = is_dtlb ? DTLB_BASE : ITLB_BASE. addr = base + CORE_ID*CORE_STRIDE + (vpn[INDEX_BITS-1:0] << 2). The sum is modulo 2^ADDR_WIDTH; higher VPN bits are ignored (aliasing is intended).
- REQ: mem_req_valid=1 and addr is held stable until mem_req_ready. mem_req_ready=1 -> WAIT. flush while in REQ without ready -> IDLE, no request issued. flush together with ready -> WAIT with abort=1.
- WAIT: flush sets abort=1. On mem_rsp_valid, capture data and go to FILL. A response in the same cycle as the handshake is not expected; a response in REQ is ignored.
- FILL (one cycle), then IDLE:
  - If abort: no strobe.
  - Else if PTE bit0=1: fill_valid=1 with fill_ppn=PTE[ADDR_WIDTH-1:PAGE_SHIFT].
  - Else: page_fault=1.
  - fill_is_dtlb and fill_vpn are valid whenever either strobe is high.
- Minimum latency: accept at T, request at T+1, response at T+2 earliest, strobe at T+3.
- Back-to-back: a new miss can be accepted in the IDLE cycle right after FILL. Only one refill is outstanding.

Test Plan:
- CORE_ID=0, DTLB miss vaddr 0x0001_2345, mem_req_ready immediate, rsp 0x0ABC_D001 -> mem_req_addr=0x4048; fill_valid, fill_is_dtlb=1, vpn=0x00012, ppn=0x0ABCD at accept+3.
- CORE_ID=1, ITLB miss vaddr 0x00FF_F000, rsp 0x1234_5000 -> addr=0x0000_4BFC; page_fault=1, fill_valid=0, fill_is_dtlb=0.
- DTLB and ITLB misses asserted together -> DTLB served first (dtlb_miss_ready=1, itlb_miss_ready=0); the ITLB miss is accepted in the IDLE cycle after the first FILL.
- mem_req_ready held low 5 cycles -> mem_req_valid and addr stable all 5 cycles; flush on cycle 3 -> IDLE, no handshake, no strobe.
- flush in WAIT, then rsp 0x0000_1001 -> FILL cycle with fill_valid=0 and page_fault=0; busy drops the next cycle.
- reset asserted in WAIT -> all outputs 0 next cycle; a later mem_rsp_valid produces no strobe.
